// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: host-side command sequencer for a PS/2 keyboard.
// Runs init (FF / BAT / F4 / LED), LED updates and hot-plug re-enable,
// handles ACK, resend, timeouts and retries, and forwards all other
// received bytes as key bytes.
module ps2_command_sequencer #(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 240000,
  parameter int unsigned BAT_TIMEOUT_CYCLES = 12000000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_req,
  input  logic       led_req,
  input  logic [2:0] led_state,
  input  logic       ps2_busy,
  input  logic       ps2_read,
  input  logic [7:0] ps2_rx_data,
  output logic       ps2_write,
  output logic [7:0] ps2_tx_data,
  output logic       key_valid,
  output logic [7:0] key_data,
  output logic       ready,
  output logic       kbd_ok,
  output logic       error
);

  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_LEDS   = 8'hED;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_BAT_ER = 8'hFC;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_BAT} state_e;
  // Every sequence is a tail of FF -> F4 -> ED -> LED byte; the sequence
  // kind only picks the entry step and whether completion sets kbd_ok.
  typedef enum logic [1:0] {STEP_FF, STEP_F4, STEP_ED, STEP_LED} step_e;
  typedef enum logic [1:0] {SEQ_INIT, SEQ_LED, SEQ_REEN} seq_e;

  state_e        state_q, state_d;
  step_e         step_q, step_d;
  seq_e          seq_q, seq_d;
  logic [31:0]   timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          rst_pend_q, rst_pend_d;
  logic          led_pend_q, led_pend_d;
  logic [2:0]    led_q, led_d;
  logic          write_q, write_d;
  logic [7:0]    tx_q, tx_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_data_q, key_data_d;
  logic          ready_q, ready_d;
  logic          kbd_ok_q, kbd_ok_d;
  logic          error_q, error_d;

  logic [7:0]    step_byte;
  logic          start_init, start_led, start_reen;
  logic          resend, seq_done, seq_fail, forward;

  // Byte transmitted for the current step; the LED byte uses the latched value.
  always_comb begin
    step_byte = CMD_RESET;
    case (step_q)
      STEP_FF:  step_byte = CMD_RESET;
      STEP_F4:  step_byte = CMD_ENABLE;
      STEP_ED:  step_byte = CMD_LEDS;
      STEP_LED: step_byte = {5'b0, led_q};
      default:  step_byte = CMD_RESET;
    endcase
  end

  // Next-state logic: per-state decode raises event flags, which are then
  // resolved in one place (resend/retry, done, fail, sequence start).
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    seq_d       = seq_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    write_d     = 1'b0;
    tx_d        = tx_q;
    key_valid_d = 1'b0;
    key_data_d  = key_data_q;
    kbd_ok_d    = kbd_ok_q;
    error_d     = error_q;
    led_d       = led_req ? led_state : led_q;
    start_init  = 1'b0;
    start_led   = 1'b0;
    start_reen  = 1'b0;
    resend      = 1'b0;
    seq_done    = 1'b0;
    seq_fail    = 1'b0;
    forward     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rst_pend_q) begin
          start_init = 1'b1;
        end else if (led_pend_q) begin
          start_led = 1'b1;
        end else if (ps2_read && ps2_rx_data == RSP_BAT_OK) begin
          start_reen = 1'b1;   // hot-plugged keyboard announced itself
        end
        forward = ps2_read && !start_reen;
      end
      ST_ISSUE: begin
        if (!ps2_busy) begin
          write_d = 1'b1;
          tx_d    = step_byte;
          timer_d = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + 32'd1;
        if (ps2_read) begin
          if (ps2_rx_data == RSP_ACK) begin
            retry_d = '0;
            if (step_q == STEP_FF) begin
              timer_d = '0;
              state_d = ST_WAIT_BAT;
            end else if (step_q == STEP_LED) begin
              seq_done = 1'b1;
            end else begin
              step_d  = step_e'(step_q + 2'd1);
              state_d = ST_ISSUE;
            end
          end else if (ps2_rx_data == RSP_RESEND) begin
            resend = 1'b1;
          end else begin
            forward = 1'b1;
          end
        end else if (timer_q == ACK_TIMEOUT_CYCLES - 32'd1) begin
          resend = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        timer_d = timer_q + 32'd1;
        if (ps2_read) begin
          if (ps2_rx_data == RSP_BAT_OK) begin
            step_d  = STEP_F4;
            state_d = ST_ISSUE;
          end else if (ps2_rx_data == RSP_BAT_ER) begin
            seq_fail = 1'b1;
          end else begin
            forward = 1'b1;
          end
        end else if (timer_q == BAT_TIMEOUT_CYCLES - 32'd1) begin
          seq_fail = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (resend) begin
      if (retry_q >= RW'(MAX_RETRIES)) begin
        seq_fail = 1'b1;
      end else begin
        retry_d = retry_q + RW'(1);
        state_d = ST_ISSUE;
      end
    end

    if (seq_done) begin
      if (seq_q != SEQ_LED) kbd_ok_d = 1'b1;
      state_d = ST_IDLE;
    end

    if (seq_fail) begin
      error_d = 1'b1;
      if (seq_q == SEQ_INIT) kbd_ok_d = 1'b0;
      state_d = ST_IDLE;
    end

    if (forward) begin
      key_valid_d = 1'b1;
      key_data_d  = ps2_rx_data;
    end

    if (start_init || start_led || start_reen) begin
      error_d = 1'b0;
      retry_d = '0;
      state_d = ST_ISSUE;
      if (start_init) begin
        seq_d  = SEQ_INIT;
        step_d = STEP_FF;
      end else if (start_led) begin
        seq_d  = SEQ_LED;
        step_d = STEP_ED;
      end else begin
        seq_d  = SEQ_REEN;
        step_d = STEP_F4;
      end
    end

    // INIT ends by sending the LEDs, so starting it also absorbs a pending LED.
    rst_pend_d = (rst_pend_q & ~start_init) | reset_req;
    led_pend_d = (led_pend_q & ~start_init & ~start_led) | led_req;
    ready_d    = (state_d == ST_IDLE) && !rst_pend_d && !led_pend_d;
  end

  // State register; reset lands in ISSUE for the FF step of INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ISSUE;
      step_q      <= STEP_FF;
      seq_q       <= SEQ_INIT;
      timer_q     <= '0;
      retry_q     <= '0;
      rst_pend_q  <= 1'b0;
      led_pend_q  <= 1'b0;
      led_q       <= 3'b000;
      write_q     <= 1'b0;
      tx_q        <= 8'h00;
      key_valid_q <= 1'b0;
      key_data_q  <= 8'h00;
      ready_q     <= 1'b0;
      kbd_ok_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      seq_q       <= seq_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      rst_pend_q  <= rst_pend_d;
      led_pend_q  <= led_pend_d;
      led_q       <= led_d;
      write_q     <= write_d;
      tx_q        <= tx_d;
      key_valid_q <= key_valid_d;
      key_data_q  <= key_data_d;
      ready_q     <= ready_d;
      kbd_ok_q    <= kbd_ok_d;
      error_q     <= error_d;
    end
  end

  assign ps2_write   = write_q;
  assign ps2_tx_data = tx_q;
  assign key_valid   = key_valid_q;
  assign key_data    = key_data_q;
  assign ready       = ready_q;
  assign kbd_ok      = kbd_ok_q;
  assign error       = error_q;

endmodule
